// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 timing constants, colour type and test-bar palette
// Optional feature macro: VGA_TEST_PATTERN_EN (the palette is used only when it is defined)
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_CNT_W    = 10;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
    localparam rgb444_t [0:7] VGA_BAR_COLOURS = {
        12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
        12'hF0F, 12'hF00, 12'h00F, 12'h000
    };

endpackage

// File: rtl/vga_test_pattern.sv
// rtl/vga_test_pattern.sv - combinational eight-bar colour generator
// Ports:
//   x   in  CNT_W  horizontal position
//   de  in  1      visible-area flag; colour is forced to black when low
//   rgb out rgb444_t bar colour for this position
module vga_test_pattern
    import vga_pkg::*;
#(
    parameter int CNT_W = VGA_CNT_W,
    parameter int BAR_W = VGA_H_ACTIVE / 8
) (
    input  logic [CNT_W-1:0] x,
    input  logic             de,
    output rgb444_t          rgb
);

    logic [CNT_W-1:0] bar;

    assign bar = x / CNT_W'(BAR_W);

    always_comb begin
        rgb = '0;
        if (de && (bar < CNT_W'(8))) begin
            rgb = VGA_BAR_COLOURS[bar[2:0]];
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with registered, mutually aligned outputs
// Optional feature macro: VGA_TEST_PATTERN_EN adds registered r/g/b colour-bar outputs.
// Ports:
//   clk          in   pixel clock
//   reset        in   synchronous, active-high
//   x, y         out  CNT_W  raster position (one clock behind the counters)
//   de           out  visible-area flag
//   hsync, vsync out  syncs, active level set by HSYNC_POL / VSYNC_POL
//   line_start   out  one-clock pulse at the first pixel of each line
//   frame_start  out  one-clock pulse at the first pixel of each frame
//   r, g, b      out  4 bits each, only with VGA_TEST_PATTERN_EN
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = VGA_H_ACTIVE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_ACTIVE  = VGA_V_ACTIVE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CNT_W     = VGA_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             de,
    output logic             hsync,
    output logic             vsync,
    output logic             line_start,
    output logic             frame_start
`ifdef VGA_TEST_PATTERN_EN
    ,
    output logic [3:0]       r,
    output logic [3:0]       g,
    output logic [3:0]       b
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic             h_wrap;
    logic             v_wrap;
    logic             de_d;
    logic             hs_act;
    logic             vs_act;

    // >= rather than == so an out-of-range value still returns to 0.
    assign h_wrap = (h >= H_LAST);
    assign v_wrap = (v >= V_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (h_wrap) begin
            h <= '0;
            v <= v_wrap ? '0 : v + CNT_W'(1);
        end else begin
            h <= h + CNT_W'(1);
        end
    end

    // v only moves when h wraps, so vsync edges fall at h==0 by construction.
    assign de_d   = (h < H_VIS) && (v < V_VIS);
    assign hs_act = (h >= HS_FIRST) && (h <= HS_LAST);
    assign vs_act = (v >= VS_FIRST) && (v <= VS_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            x           <= '0;
            y           <= '0;
            de          <= 1'b0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            x           <= h;
            y           <= v;
            de          <= de_d;
            hsync       <= hs_act ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= vs_act ? VSYNC_POL : ~VSYNC_POL;
            line_start  <= (h == '0);
            frame_start <= (h == '0) && (v == '0);
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    rgb444_t bar_rgb;

    vga_test_pattern #(
        .CNT_W (CNT_W),
        .BAR_W (H_ACTIVE / 8)
    ) u_test_pattern (
        .x   (h),
        .de  (de_d),
        .rgb (bar_rgb)
    );

    // Registered from the same (h,v) decode as de so colour stays aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            r <= '0;
            g <= '0;
            b <= '0;
        end else begin
            r <= bar_rgb.r;
            g <= bar_rgb.g;
            b <= bar_rgb.b;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    localparam int S_HA = 64, S_HFP = 4, S_HS = 8, S_HBP = 6;
    localparam int S_VA = 20, S_VFP = 3, S_VS = 2, S_VBP = 4;
    localparam int S_W  = 7;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic [9:0]     d_x, d_y;
    logic           d_de, d_hs, d_vs, d_ls, d_fs;
    logic [S_W-1:0] s_x, s_y;
    logic           s_de, s_hs, s_vs, s_ls, s_fs;
`ifdef VGA_TEST_PATTERN_EN
    logic [3:0]     d_r, d_g, d_b, s_r, s_g, s_b;
`endif

    vga_timing_gen u_dflt (
        .clk         (clk),
        .reset       (reset),
        .x           (d_x),
        .y           (d_y),
        .de          (d_de),
        .hsync       (d_hs),
        .vsync       (d_vs),
        .line_start  (d_ls),
        .frame_start (d_fs)
`ifdef VGA_TEST_PATTERN_EN
        ,
        .r           (d_r),
        .g           (d_g),
        .b           (d_b)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE (S_HA), .H_FP (S_HFP), .H_SYNC (S_HS), .H_BP (S_HBP),
        .V_ACTIVE (S_VA), .V_FP (S_VFP), .V_SYNC (S_VS), .V_BP (S_VBP),
        .HSYNC_POL (1'b1), .VSYNC_POL (1'b1), .CNT_W (S_W)
    ) u_small (
        .clk         (clk),
        .reset       (reset),
        .x           (s_x),
        .y           (s_y),
        .de          (s_de),
        .hsync       (s_hs),
        .vsync       (s_vs),
        .line_start  (s_ls),
        .frame_start (s_fs)
`ifdef VGA_TEST_PATTERN_EN
        ,
        .r           (s_r),
        .g           (s_g),
        .b           (s_b)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    typedef struct {
        int x;
        int y;
        bit de;
        bit hs;
        bit vs;
        bit ls;
        bit fs;
        int rgb;
    } exp_t;

    // Reference: output index k after reset release maps to pixel k of an endless raster.
    function automatic exp_t model(input int ha, hfp, hsw, hbp, va, vfp, vsw, vbp,
                                   input bit hpol, vpol, input bit rst, input longint k);
        exp_t e;
        int   ht, vt, h, v;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        e.rgb = 0;
        if (rst) begin
            e.x = 0; e.y = 0; e.de = 0; e.ls = 0; e.fs = 0;
            e.hs = ~hpol; e.vs = ~vpol;
            return e;
        end
        h = int'(k % ht);
        v = int'((k / ht) % vt);
        e.x  = h;
        e.y  = v;
        e.de = (h < ha) && (v < va);
        e.hs = (h >= ha + hfp && h < ha + hfp + hsw) ? hpol : ~hpol;
        e.vs = (v >= va + vfp && v < va + vfp + vsw) ? vpol : ~vpol;
        e.ls = (h == 0);
        e.fs = (h == 0) && (v == 0);
        if (e.de) begin
            case (h / (ha / 8))
                0: e.rgb = 'hFFF;
                1: e.rgb = 'hFF0;
                2: e.rgb = 'h0FF;
                3: e.rgb = 'h0F0;
                4: e.rgb = 'hF0F;
                5: e.rgb = 'hF00;
                6: e.rgb = 'h00F;
                default: e.rgb = 'h000;
            endcase
        end
        return e;
    endfunction

    task automatic cmp(input string tag, input logic [31:0] x, y,
                       input logic de, hs, vs, ls, fs, input exp_t e);
        chk({tag, ".x"}, x, e.x);
        chk({tag, ".y"}, y, e.y);
        chk({tag, ".de"}, 32'(de), 32'(e.de));
        chk({tag, ".hsync"}, 32'(hs), 32'(e.hs));
        chk({tag, ".vsync"}, 32'(vs), 32'(e.vs));
        chk({tag, ".line_start"}, 32'(ls), 32'(e.ls));
        chk({tag, ".frame_start"}, 32'(fs), 32'(e.fs));
    endtask

    // Model state: m_rst = last edge was a reset edge; m_k = output index since release.
    bit     chk_en = 1'b0;
    bit     m_rst  = 1'b1;
    longint m_k    = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_rst <= 1'b1;
        end else begin
            m_rst <= 1'b0;
            m_k   <= m_rst ? 0 : m_k + 1;
        end
    end

    int d_de_line, d_hs_line;
    bit d_line_ok, d_line_vis;
    int s_de_frm, s_vs_frm, s_len_frm, s_len_line;
    bit s_frm_ok, s_line_ok;

    always @(negedge clk) begin
        exp_t ed, es;
        if (chk_en) begin
            ed = model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, m_rst, m_k);
            es = model(S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, 1'b1, 1'b1, m_rst, m_k);
            cmp("dflt", 32'(d_x), 32'(d_y), d_de, d_hs, d_vs, d_ls, d_fs, ed);
            cmp("small", 32'(s_x), 32'(s_y), s_de, s_hs, s_vs, s_ls, s_fs, es);
`ifdef VGA_TEST_PATTERN_EN
            chk("dflt.rgb", {20'd0, d_r, d_g, d_b}, ed.rgb);
            chk("small.rgb", {20'd0, s_r, s_g, s_b}, es.rgb);
`endif
            if (m_rst) begin
                d_line_ok <= 1'b0;
                s_frm_ok  <= 1'b0;
                s_line_ok <= 1'b0;
            end else begin
                if (d_ls) begin
                    if (d_line_ok) begin
                        chk("dflt.de_per_line", d_de_line, d_line_vis ? 640 : 0);
                        chk("dflt.hsync_low_per_line", d_hs_line, 96);
                    end
                    d_line_ok  <= 1'b1;
                    d_line_vis <= (ed.y < 480);
                    d_de_line  <= int'(d_de);
                    d_hs_line  <= int'(!d_hs);
                end else begin
                    d_de_line <= d_de_line + int'(d_de);
                    d_hs_line <= d_hs_line + int'(!d_hs);
                end
                if (s_fs) begin
                    if (s_frm_ok) begin
                        chk("small.de_per_frame", s_de_frm, S_HA * S_VA);
                        chk("small.vsync_per_frame", s_vs_frm, S_VS * 82);
                        chk("small.frame_period", s_len_frm, 82 * 29);
                    end
                    s_frm_ok  <= 1'b1;
                    s_de_frm  <= int'(s_de);
                    s_vs_frm  <= int'(s_vs);
                    s_len_frm <= 1;
                end else begin
                    s_de_frm  <= s_de_frm + int'(s_de);
                    s_vs_frm  <= s_vs_frm + int'(s_vs);
                    s_len_frm <= s_len_frm + 1;
                end
                if (s_ls) begin
                    if (s_line_ok) chk("small.line_period", s_len_line, 82);
                    s_line_ok  <= 1'b1;
                    s_len_line <= 1;
                end else begin
                    s_len_line <= s_len_line + 1;
                end
            end
        end
    end

    typedef struct {
        longint k;
        int     x;
        int     y;
        bit     de;
        bit     hs;
        bit     vs;
        bit     ls;
        bit     fs;
        int     rgb;
    } vec_t;

    vec_t vecs[$];

    task automatic wait_k(input longint k, input string name);
        int guard;
        guard = 0;
        while ((m_rst || m_k != k) && guard < 30000) begin
            @(negedge clk);
            guard++;
        end
        chk({name, ".reach"}, 32'(m_k), 32'(k));
    endtask

    initial begin
        // Default timing, active-low syncs: hsync low 656..751.
        vecs.push_back('{0,    0,   0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 'hFFF});
        vecs.push_back('{1,    1,   0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 'hFFF});
        vecs.push_back('{79,   79,  0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 'hFFF});
        vecs.push_back('{80,   80,  0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 'hFF0});
        vecs.push_back('{639,  639, 0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 'h000});
        vecs.push_back('{640,  640, 0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 'h000});
        vecs.push_back('{655,  655, 0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 'h000});
        vecs.push_back('{656,  656, 0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 'h000});
        vecs.push_back('{751,  751, 0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 'h000});
        vecs.push_back('{752,  752, 0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 'h000});
        vecs.push_back('{799,  799, 0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 'h000});
        vecs.push_back('{800,  0,   1,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 'hFFF});
        vecs.push_back('{8085, 85,  10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 'hFF0});
        vecs.push_back('{8400, 400, 10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 'hF00});
        vecs.push_back('{8600, 600, 10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 'h000});
        vecs.push_back('{8700, 700, 10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 'h000});

        reset = 1'b1;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst.x", 32'(d_x), 0);
        chk("rst.y", 32'(d_y), 0);
        chk("rst.de", 32'(d_de), 0);
        chk("rst.hsync", 32'(d_hs), 1);
        chk("rst.vsync", 32'(d_vs), 1);
        chk("rst.frame_start", 32'(d_fs), 0);
        chk("rst.small_hsync", 32'(s_hs), 0);
        chk("rst.small_vsync", 32'(s_vs), 0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            wait_k(vecs[i].k, nm);
            chk({nm, ".x"}, 32'(d_x), vecs[i].x);
            chk({nm, ".y"}, 32'(d_y), vecs[i].y);
            chk({nm, ".de"}, 32'(d_de), 32'(vecs[i].de));
            chk({nm, ".hsync"}, 32'(d_hs), 32'(vecs[i].hs));
            chk({nm, ".vsync"}, 32'(d_vs), 32'(vecs[i].vs));
            chk({nm, ".line_start"}, 32'(d_ls), 32'(vecs[i].ls));
            chk({nm, ".frame_start"}, 32'(d_fs), 32'(vecs[i].fs));
`ifdef VGA_TEST_PATTERN_EN
            chk({nm, ".rgb"}, {20'd0, d_r, d_g, d_b}, vecs[i].rgb);
`endif
        end

        // One-clock reset mid-frame at (300,20).
        wait_k(20 * 800 + 300, "midrst");
        chk("midrst.x_before", 32'(d_x), 300);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst.x", 32'(d_x), 0);
        chk("midrst.y", 32'(d_y), 0);
        chk("midrst.de", 32'(d_de), 0);
        chk("midrst.hsync", 32'(d_hs), 1);
        chk("midrst.line_start", 32'(d_ls), 0);
        @(negedge clk);
        chk("midrst.frame_start", 32'(d_fs), 1);
        chk("midrst.line_start_after", 32'(d_ls), 1);
        chk("midrst.x_after", 32'(d_x), 0);
        chk("midrst.y_after", 32'(d_y), 0);
        chk("midrst.de_after", 32'(d_de), 1);

        // Randomised run lengths and reset pulses, checked every cycle by the model.
        repeat (12) begin
            repeat ($urandom_range(300, 2500)) @(negedge clk);
            if ($urandom_range(0, 1) == 1) begin
                reset = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                reset = 1'b0;
            end
        end

        // Clean stretch covering more than two small-raster frames.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3 * 82 * 29 + 50) @(negedge clk);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
